// File: rtl/ahb3_arbiter.sv
// Round-robin arbiter that sequences SETUP/ENABLE transfers onto a shared AHB3-Lite slave.
// Optional AHB3_ARB_LOCK_EN: lets a requester keep the grant across back-to-back transfers.
module ahb3_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned IdW  = $clog2(NREQ)
) (
    input  logic              hclk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*32-1:0] addr,
    input  logic [NREQ*32-1:0] wdata,
`ifdef AHB3_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    output logic [NREQ-1:0]   ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [IdW-1:0]    gnt_id,
    output logic              hsel,
    output logic              hwrite,
    output logic              hready,
    output logic              hmastlock,
    output logic [31:0]       haddr,
    output logic [31:0]       hwdata,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    input  logic [31:0]       hrdata,
    input  logic              hresp
);

    typedef enum logic [1:0] {StIdle, StSetup, StEnable, StDone} state_e;

    state_e          state_q;
    logic [IdW-1:0]  last_q;
    logic            we_q;
    logic            err_q;
    logic [31:0]     wdata_q;
    logic [IdW-1:0]  win;
    logic            win_lock;
    logic [31:0]     addr_arr  [NREQ];
    logic [31:0]     wdata_arr [NREQ];
`ifdef AHB3_ARB_LOCK_EN
    logic            lock_q;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr[32*g +: 32];
        assign wdata_arr[g] = wdata[32*g +: 32];
    end

    assign hsize  = 3'b010;
    assign hburst = 3'b000;
    assign hprot  = 4'b0011;

    // Read data and slave error are only meaningful while acknowledging.
    assign rdata = (state_q == StDone && !we_q && !err_q) ? hrdata : 32'h0;
    assign err   = err_q | ((state_q == StDone) & hresp);

    // Descending scan so the closest requester after last_q is the one left in win.
    always_comb begin
        logic [IdW-1:0] cand;
        win      = '0;
        win_lock = 1'b0;
        cand     = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = IdW'((int'(last_q) + k) % int'(NREQ));
            if (req[cand]) win = cand;
        end
`ifdef AHB3_ARB_LOCK_EN
        if (lock_q && req[gnt_id]) win = gnt_id;
        win_lock = lock[win];
`endif
    end

    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= IdW'(NREQ - 1);
            gnt_id    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            ack       <= '0;
            hsel      <= 1'b0;
            hready    <= 1'b0;
            hwrite    <= 1'b0;
            hmastlock <= 1'b0;
            htrans    <= 2'b00;
            haddr     <= '0;
            hwdata    <= '0;
`ifdef AHB3_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef AHB3_ARB_LOCK_EN
                    lock_q <= 1'b0;
`endif
                    if (|req) begin
                        gnt_id  <= win;
                        last_q  <= win;
                        we_q    <= we[win];
                        wdata_q <= wdata_arr[win];
                        if (addr_arr[win] >= DEPTH) begin
                            err_q   <= 1'b1;
                            ack     <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                            state_q <= StDone;
                        end else begin
                            hsel      <= 1'b1;
                            htrans    <= 2'b10;
                            hwrite    <= we[win];
                            haddr     <= addr_arr[win];
                            hmastlock <= win_lock;
                            state_q   <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    hready  <= 1'b1;
                    htrans  <= 2'b00;
                    hwdata  <= wdata_q;
                    state_q <= StEnable;
                end
                StEnable: begin
                    hsel      <= 1'b0;
                    hready    <= 1'b0;
                    hwrite    <= 1'b0;
                    hmastlock <= 1'b0;
                    haddr     <= '0;
                    hwdata    <= '0;
                    ack       <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
                    state_q   <= StDone;
                end
                StDone: begin
                    ack     <= '0;
                    err_q   <= 1'b0;
                    we_q    <= 1'b0;
`ifdef AHB3_ARB_LOCK_EN
                    lock_q  <= lock[gnt_id];
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3_arbiter.sv
// Self-checking bench for ahb3_arbiter: vector table, scoreboard on ack, and corner sequences.
// Build with AHB3_ARB_LOCK_EN defined to also exercise the grant-lock sequence.
module tb_ahb3_arbiter;

    logic         hclk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, we, lock;
    logic [127:0] addr, wdata;
    logic [3:0]   ack;
    logic [31:0]  rdata, haddr, hwdata, hrdata;
    logic         err, hsel, hwrite, hready, hmastlock;
    logic         hresp = 1'b0;
    logic [1:0]   gnt_id, htrans;
    logic [2:0]   hsize, hburst;
    logic [3:0]   hprot;
    logic [31:0]  mem [256];

    always #5 hclk = ~hclk;

    ahb3_arbiter #(.NREQ(4), .DEPTH(256)) dut (
        .hclk(hclk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef AHB3_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack), .rdata(rdata), .err(err), .gnt_id(gnt_id),
        .hsel(hsel), .hwrite(hwrite), .hready(hready), .hmastlock(hmastlock),
        .haddr(haddr), .hwdata(hwdata), .htrans(htrans), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hrdata(hrdata), .hresp(hresp)
    );

    // Slave model: shares the reset, writes at the ENABLE->DONE edge, read data valid in DONE.
    always_ff @(posedge hclk) begin
        if (!rst_n) begin
            hrdata <= 32'h0;
        end else begin
            hrdata <= 32'h0;
            if (hsel && hready) begin
                if (hwrite) mem[haddr[7:0]] <= hwdata;
                else hrdata <= mem[haddr[7:0]];
            end
        end
    end

    typedef struct {
        int          id;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] rd;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endtask

    always @(negedge hclk) begin
        exp_t e;
        if (rst_n) begin
            if (ack != 4'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%b required=none", ack);
                end else begin
                    e = sb.pop_front();
                    check("sb_ack", 32'(ack), 32'(e.ack));
                    check("sb_rdata", rdata, e.rd);
                    check("sb_err", 32'(err), 32'(e.e));
                end
            end else begin
                check("idle_rdata_err", {rdata[31:1], rdata[0] | err}, 32'h0);
            end
        end
    end

    task automatic push_exp(input int id, input logic [31:0] rd, input logic e_v);
        exp_t e;
        e.ack = 4'b0001 << id;
        e.rd  = rd;
        e.e   = e_v;
        sb.push_back(e);
    endtask

    task automatic drive(input int id, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[id]           = 1'b1;
        we[id]            = w;
        addr[id*32 +: 32]  = a;
        wdata[id*32 +: 32] = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 32'h0);
        check({tag, "_hsel_hready_hwrite_hmastlock"}, 32'({hsel, hready, hwrite, hmastlock}), 32'h0);
        check({tag, "_htrans"}, 32'(htrans), 32'h0);
        check({tag, "_haddr"}, haddr, 32'h0);
        check({tag, "_hwdata"}, hwdata, 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_consts"}, {22'h0, hsize, hburst, hprot}, {22'h0, 3'b010, 3'b000, 4'b0011});
    endtask

    task automatic reset_pulse();
        @(negedge hclk);
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (2) @(negedge hclk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, hs, ml;
        bit seen;
        @(negedge hclk);
        drive(v.id, v.w, v.a, v.d);
        push_exp(v.id, v.exp_rd, v.exp_err);
        lat  = 0;
        hs   = 0;
        ml   = 0;
        seen = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge hclk);
            if (hsel) hs++;
            if (hmastlock) ml++;
            if (c == 1 && !v.exp_err) begin
                check("setup_phase", {hsel, hready, htrans, hwrite}, {1'b1, 1'b0, 2'b10, v.w});
                check("setup_haddr", haddr, v.a);
            end
            if (c == 2 && !v.exp_err) begin
                check("enable_phase", {hsel, hready, htrans}, {1'b1, 1'b1, 2'b00});
                if (v.w) check("enable_hwdata", hwdata, v.d);
            end
            if (ack != 4'b0) begin
                lat  = c;
                seen = 1;
                check("gnt_id", 32'(gnt_id), 32'(v.id));
            end
        end
        req[v.id] = 1'b0;
        check("latency", lat, v.exp_err ? 1 : 3);
        check("hsel_cycles", hs, v.exp_err ? 0 : 2);
        check("hmastlock_cycles", ml, 0);
    endtask

    vec_t tbl[8];
    int   t[4];
    int   n, n0, ml;

    initial begin
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge hclk);
        check_quiet("reset");
        rst_n = 1'b1;

        tbl[0] = '{id: 2, w: 1, a: 32'h10, d: 32'hDEADBEEF, exp_rd: 32'h0,        exp_err: 0};
        tbl[1] = '{id: 2, w: 0, a: 32'h10, d: 32'h0,        exp_rd: 32'hDEADBEEF, exp_err: 0};
        tbl[2] = '{id: 1, w: 0, a: 300,    d: 32'h0,        exp_rd: 32'h0,        exp_err: 1};
        tbl[3] = '{id: 3, w: 1, a: 32'hFF, d: 32'h12345678, exp_rd: 32'h0,        exp_err: 0};
        tbl[4] = '{id: 3, w: 0, a: 32'hFF, d: 32'h0,        exp_rd: 32'h12345678, exp_err: 0};
        tbl[5] = '{id: 0, w: 1, a: 32'h20, d: 32'hA5A5A5A5, exp_rd: 32'h0,        exp_err: 0};
        tbl[6] = '{id: 0, w: 0, a: 32'h20, d: 32'h0,        exp_rd: 32'hA5A5A5A5, exp_err: 0};
        tbl[7] = '{id: 1, w: 1, a: 256,    d: 32'h55555555, exp_rd: 32'h0,        exp_err: 1};
        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset in the ENABLE phase of a write: nothing acknowledged, memory untouched.
        @(negedge hclk);
        drive(0, 1'b1, 32'h20, 32'h11111111);
        repeat (2) @(negedge hclk);
        check("abort_in_enable", {hsel, hready, hwrite}, 3'b111);
        rst_n = 1'b0;
        @(negedge hclk);
        check_quiet("midreset");
        req   = '0;
        rst_n = 1'b1;
        run_vec('{id: 1, w: 0, a: 32'h20, d: 32'h0, exp_rd: 32'hA5A5A5A5, exp_err: 0});

        // All four requesting after reset: grants 0,1,2,3 spaced one transfer apart.
        reset_pulse();
        @(negedge hclk);
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'hFF, 32'h0);
        drive(2, 1'b0, 32'h20, 32'h0);
        drive(3, 1'b0, 32'h10, 32'h0);
        push_exp(0, 32'hDEADBEEF, 0);
        push_exp(1, 32'h12345678, 0);
        push_exp(2, 32'hA5A5A5A5, 0);
        push_exp(3, 32'hDEADBEEF, 0);
        n = 0;
        t = '{0, 0, 0, 0};
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge hclk);
            if (ack != 4'b0) begin
                t[n] = c;
                req  = req & ~ack;
                n++;
            end
        end
        check("rr_ack_count", n, 4);
        check("rr_first_latency", t[0], 3);
        for (int i = 1; i < 4; i++) check("rr_spacing", t[i] - t[i-1], 4);
        req = '0;

`ifdef AHB3_ARB_LOCK_EN
        // Requester 0 keeps the bus for three locked transfers, then requester 1 gets it.
        reset_pulse();
        @(negedge hclk);
        drive(0, 1'b0, 32'h10, 32'h0);
        lock[0] = 1'b1;
        drive(1, 1'b0, 32'hFF, 32'h0);
        push_exp(0, 32'hDEADBEEF, 0);
        push_exp(0, 32'hDEADBEEF, 0);
        push_exp(0, 32'hDEADBEEF, 0);
        push_exp(1, 32'h12345678, 0);
        n  = 0;
        n0 = 0;
        ml = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(negedge hclk);
            if (hmastlock) ml++;
            if (ack != 4'b0) begin
                n++;
                if (ack[0]) begin
                    n0++;
                    if (n0 == 3) begin
                        req[0]  = 1'b0;
                        lock[0] = 1'b0;
                    end
                end
                if (ack[1]) req[1] = 1'b0;
            end
        end
        check("lock_ack_count", n, 4);
        check("lock_req0_acks", n0, 3);
        check("lock_hmastlock_cycles", ml, 6);
        req = '0;
`endif

        repeat (3) @(negedge hclk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
